// File: rtl/spi_master.sv
// SPI master sending a 2-bit command plus WIDTH-bit payload per frame, with MISO capture for read-data frames.
// Optional macro SPI_MASTER_SEQ_CHECK_EN: reject read-data (cmd=11) unless the previous completed frame was read-address (cmd=10).
module spi_master #(
    parameter int WIDTH  = 8,
    parameter int RD_LAT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       cmd,
    input  logic [WIDTH-1:0] tx_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             err,
    input  logic             MISO,
    output logic             MOSI,
    output logic             SS_n
);

    localparam int FW    = WIDTH + 2;
    localparam int CNT_W = $clog2(FW + RD_LAT + 1);
    localparam int WAIT_LAST = (RD_LAT > 0) ? RD_LAT - 1 : 0;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SELECT  = 3'd1;
    localparam logic [2:0] S_SHIFT   = 3'd2;
    localparam logic [2:0] S_WAIT    = 3'd3;
    localparam logic [2:0] S_CAPTURE = 3'd4;
    localparam logic [2:0] S_GAP     = 3'd5;

    logic [2:0]       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [FW-1:0]    shift_reg, shift_next;
    logic [WIDTH-1:0] rx_shift_reg, rx_shift_next;
    logic [WIDTH-1:0] rx_data_reg, rx_data_next;
    logic [1:0]       cmd_reg, cmd_next;
    logic [WIDTH-1:0] rx_word;
    logic             reject;

`ifdef SPI_MASTER_SEQ_CHECK_EN
    logic seq_reg;
    logic err_reg;

    assign reject = (cmd == 2'b11) && !seq_reg;
    assign err    = err_reg;

    // The flag reflects only completed frames; rejected requests leave it untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_reg <= 1'b0;
            err_reg <= 1'b0;
        end else begin
            err_reg <= (state_reg == S_IDLE) && start && reject;
            if (state_reg == S_GAP)
                seq_reg <= (cmd_reg == 2'b10);
        end
    end
`else
    assign reject = 1'b0;
    assign err    = 1'b0;
`endif

    assign rx_word = {rx_shift_reg[WIDTH-2:0], MISO};

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        shift_next    = shift_reg;
        rx_shift_next = rx_shift_reg;
        rx_data_next  = rx_data_reg;
        cmd_next      = cmd_reg;
        case (state_reg)
            S_IDLE: begin
                if (start && !reject) begin
                    shift_next = {cmd, tx_data};
                    cmd_next   = cmd;
                    cnt_next   = CNT_W'(1);
                    state_next = S_SELECT;
                end
            end
            S_SELECT: begin
                if (cnt_reg == '0) begin
                    cnt_next   = CNT_W'(FW - 1);
                    state_next = S_SHIFT;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            S_SHIFT: begin
                shift_next = {shift_reg[FW-2:0], 1'b0};
                if (cnt_reg == '0) begin
                    if (cmd_reg != 2'b11) begin
                        state_next = S_GAP;
                    end else if (RD_LAT == 0) begin
                        cnt_next   = CNT_W'(WIDTH - 1);
                        state_next = S_CAPTURE;
                    end else begin
                        cnt_next   = CNT_W'(WAIT_LAST);
                        state_next = S_WAIT;
                    end
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            S_WAIT: begin
                if (cnt_reg == '0) begin
                    cnt_next   = CNT_W'(WIDTH - 1);
                    state_next = S_CAPTURE;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            S_CAPTURE: begin
                rx_shift_next = rx_word;
                if (cnt_reg == '0) begin
                    // Publish on the same edge that enters GAP so rx_data lines up with done.
                    rx_data_next = rx_word;
                    state_next   = S_GAP;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            S_GAP: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            cnt_reg      <= '0;
            shift_reg    <= '0;
            rx_shift_reg <= '0;
            rx_data_reg  <= '0;
            cmd_reg      <= '0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            shift_reg    <= shift_next;
            rx_shift_reg <= rx_shift_next;
            rx_data_reg  <= rx_data_next;
            cmd_reg      <= cmd_next;
        end
    end

    assign busy     = (state_reg != S_IDLE);
    assign done     = (state_reg == S_GAP);
    assign rx_valid = (state_reg == S_GAP) && (cmd_reg == 2'b11);
    assign rx_data  = rx_data_reg;
    assign SS_n     = (state_reg == S_IDLE) || (state_reg == S_GAP);
    assign MOSI     = ((state_reg == S_SELECT) || (state_reg == S_SHIFT)) ? shift_reg[FW-1] : 1'b0;

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: directed frames followed by randomized frames against a frame-level model.
module tb_spi_master;

    localparam int W   = 8;
    localparam int RDL = 2;
`ifdef SPI_MASTER_SEQ_CHECK_EN
    localparam bit SEQ_EN = 1'b1;
`else
    localparam bit SEQ_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [1:0]   cmd;
    logic [W-1:0] tx_data;
    logic         busy, done, rx_valid, err, MISO, MOSI, SS_n;
    logic [W-1:0] rx_data;

    int tests = 0;
    int fails = 0;

    // Frame-level model state: last captured byte and whether the last completed frame was cmd=10.
    logic [W-1:0] model_rx;
    bit           model_seq;

    spi_master #(.WIDTH(W), .RD_LAT(RDL)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cmd(cmd), .tx_data(tx_data),
        .busy(busy), .done(done), .rx_data(rx_data), .rx_valid(rx_valid), .err(err),
        .MISO(MISO), .MOSI(MOSI), .SS_n(SS_n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issues one request at a negedge and follows it to the IDLE cycle after done.
    task automatic do_frame(input logic [1:0] c, input logic [W-1:0] d, input logic [W-1:0] sb, input bit noise);
        bit          rej;
        int          exp_low, low, dones, cap0;
        logic [63:0] exp_bits, obs_bits;
        bit          busy_ok, err_seen;
        logic        first_ss, got_rv;
        logic [W-1:0] got_rx;

        rej = SEQ_EN && (c == 2'b11) && !model_seq;
        start = 1'b1; cmd = c; tx_data = d;
        @(negedge clk);
        if (rej) begin
            start = 1'b0;
            chk("rej_err", err, 1);
            chk("rej_ss_high", SS_n, 1);
            chk("rej_busy", busy, 0);
            @(negedge clk);
            chk("rej_err_pulse_end", err, 0);
            chk("rej_ss_still_high", SS_n, 1);
            $display("[TB] frame cmd=%0d tx=%02h rejected", c, d);
            return;
        end

        exp_low = (c == 2'b11) ? 2 * W + 4 + RDL : W + 4;
        cap0    = W + 4 + RDL;
        exp_bits = '0;
        // Expected serial stream: cmd[1] twice in SELECT, then cmd, then payload MSB first, zeros afterwards.
        exp_bits = (exp_bits << 1) | 64'(c[1]);
        exp_bits = (exp_bits << 1) | 64'(c[1]);
        exp_bits = (exp_bits << 1) | 64'(c[1]);
        exp_bits = (exp_bits << 1) | 64'(c[0]);
        for (int i = W - 1; i >= 0; i--) exp_bits = (exp_bits << 1) | 64'(d[i]);
        for (int i = W + 4; i < exp_low; i++) exp_bits = exp_bits << 1;

        obs_bits = '0; low = 0; dones = 0; busy_ok = 1; err_seen = 0;
        got_rv = 1'b0; got_rx = '0;
        first_ss = SS_n;
        for (int k = 0; k < 3 * W + RDL + 10; k++) begin
            if (noise && k < exp_low) begin
                start = 1'($urandom); cmd = 2'($urandom); tx_data = W'($urandom);
            end else begin
                start = 1'b0;
            end
            if (!SS_n) begin
                if (c == 2'b11 && low >= cap0 && low < cap0 + W) MISO = sb[W - 1 - (low - cap0)];
                else MISO = 1'($urandom);
                obs_bits = (obs_bits << 1) | 64'(MOSI);
                low++;
            end else begin
                MISO = 1'($urandom);
            end
            if (!busy) busy_ok = 0;
            if (err) err_seen = 1;
            if (done) begin
                dones++;
                got_rv = rx_valid;
                got_rx = rx_data;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("ss_falls_first_cycle", first_ss, 0);
        chk("done_seen", dones, 1);
        chk("ss_low_cycles", low, exp_low);
        chk("mosi_stream", obs_bits, exp_bits);
        chk("busy_through_frame", busy_ok, 1);
        chk("no_err_in_frame", err_seen, 0);
        chk("rx_valid_at_done", got_rv, (c == 2'b11));
        if (c == 2'b11) model_rx = sb;
        chk("rx_data_at_done", got_rx, model_rx);
        model_seq = (c == 2'b10);
        @(negedge clk);
        chk("idle_busy_low", busy, 0);
        chk("idle_no_done", done, 0);
        chk("idle_ss_high", SS_n, 1);
        $display("[TB] frame cmd=%0d tx=%02h ss_low=%0d rx=%02h noise=%0d", c, d, low, got_rx, noise);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; cmd = 2'b00; tx_data = '0; MISO = 1'b0;
        model_rx = '0; model_seq = 0;
        repeat (3) @(negedge clk);
        chk("rst_ss", SS_n, 1);
        chk("rst_mosi", MOSI, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_err", err, 0);
        chk("rst_rx_data", rx_data, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_idle_ss", SS_n, 1);

        // Directed frames, back to back.
        do_frame(2'b00, 8'hA5, 8'h00, 0);
        do_frame(2'b01, 8'h3C, 8'h00, 0);
        do_frame(2'b10, 8'h5A, 8'h00, 0);
        do_frame(2'b11, 8'h00, 8'hC3, 0);
        // Write frame after a read: flag clears, rx_data held.
        do_frame(2'b01, 8'hFF, 8'h00, 0);
        // Read-data without a preceding read-address.
        do_frame(2'b11, 8'h12, 8'h81, 0);
        do_frame(2'b10, 8'h77, 8'h00, 0);
        do_frame(2'b11, 8'h34, 8'h6E, 0);
        // Request inputs toggling while busy.
        do_frame(2'b00, 8'h96, 8'h00, 1);

        // Asynchronous reset in the middle of SHIFT of a write-address frame.
        start = 1'b1; cmd = 2'b00; tx_data = 8'hE7;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_ss", SS_n, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_mosi", MOSI, 0);
        chk("midrst_done", done, 0);
        chk("midrst_rx_data", rx_data, 0);
        model_rx = '0; model_seq = 0;
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int d_cnt, l_cnt;
            d_cnt = 0; l_cnt = 0;
            for (int k = 0; k < 30; k++) begin
                @(negedge clk);
                if (done) d_cnt++;
                if (!SS_n) l_cnt++;
            end
            chk("midrst_no_done", d_cnt, 0);
            chk("midrst_no_resume", l_cnt, 0);
            $display("[TB] mid-frame reset: done=%0d ss_low=%0d", d_cnt, l_cnt);
        end

        // Randomized frames; read-data frames favoured to exercise capture and sequencing.
        for (int n = 0; n < 24; n++) begin
            logic [1:0] rc;
            rc = ($urandom_range(0, 2) == 0) ? 2'b11 : 2'($urandom);
            do_frame(rc, W'($urandom), W'($urandom), bit'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter WIDTH, default 8: payload bits per frame; each frame carries 2 command bits plus WIDTH payload bits.
REQ-002 Parameter RD_LAT, default 2: idle clk cycles between the last MOSI bit of a read-data frame and the first MISO sample.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  host request; sampled only in IDLE.
REQ-006 cmd  input  2  00 write-address, 01 write-data, 10 read-address, 11 read-data.
REQ-007 tx_data  input  WIDTH  payload (address or write data).
REQ-008 busy  output  1  high from the cycle after start is accepted until done.
REQ-009 done  output  1  one-cycle pulse at frame end.
REQ-010 rx_data  output  WIDTH  byte captured from MISO on read-data frames.
REQ-011 rx_valid  output  1  one-cycle pulse, coincident with done, on read-data frames only.
REQ-012 err  output  1  one-cycle pulse on a rejected request (see Configuration).
REQ-013 MISO  input  1  serial data from slave.
REQ-014 MOSI  output  1  serial data to slave.
REQ-015 SS_n  output  1  slave select, active-low.

Function
REQ-016 FSM states: IDLE, SELECT, SHIFT, WAIT, CAPTURE, GAP.
REQ-017 IDLE: SS_n=1, MOSI=0, busy=0; start=1 latches cmd and tx_data into a (WIDTH+2)-bit shift register {cmd,tx_data}; next state SELECT.
REQ-018 SELECT lasts 2 cycles: SS_n=0, MOSI=cmd[1] in both (slave command-check cycles); then SHIFT.
REQ-019 SHIFT lasts WIDTH+2 cycles: MOSI = shift-register MSB, shift left by 1 each cycle; cmd[1], cmd[0], then tx_data MSB first.
REQ-020 After SHIFT: cmd=11 goes to WAIT; all other commands go to GAP.
REQ-021 WAIT lasts RD_LAT cycles, SS_n=0, MOSI=0; RD_LAT=0 skips WAIT.
REQ-022 CAPTURE lasts WIDTH cycles, SS_n=0, MOSI=0; MISO shifted in MSB first each cycle; then GAP.
REQ-023 GAP lasts 1 cycle: SS_n=1, done=1, rx_valid=1 only if frame was cmd=11, rx_data updated in same cycle; next state IDLE.
REQ-024 start, cmd, tx_data changes while busy are ignored; latched values govern the whole frame.
REQ-025 Frame length from SS_n fall to SS_n rise: WIDTH+4 cycles for write/read-address frames, 2*WIDTH+4+RD_LAT for read-data frames.
REQ-026 Minimum SS_n high time between frames: 2 cycles (GAP plus IDLE); back-to-back start in IDLE accepted immediately.
REQ-027 rx_data holds its last value until the next read-data frame completes.

Reset
REQ-028 rst_n low, at any time including mid-frame: state IDLE, SS_n=1, MOSI=0, busy=0, done=0, rx_valid=0, err=0, rx_data=0, shift registers and counters 0, sequence flag cleared.
REQ-029 A frame aborted by reset is not resumed and produces no done.

Configuration
REQ-030 Macro SPI_MASTER_SEQ_CHECK_EN defined: a start with cmd=11 is rejected unless the most recently completed frame was cmd=10; rejection: err pulses 1 cycle, stays IDLE, SS_n stays high; the flag is cleared after any completed frame other than cmd=10.
REQ-031 Macro undefined: all commands accepted in any order; err tied to 0.

Verification
REQ-032 Reset mid-SHIFT of a cmd=00 frame -> SS_n=1, busy=0 within the reset cycle; no done.
REQ-033 start, cmd=00, tx_data=8'hA5 -> SS_n low 12 cycles, MOSI = 0,0,0,0,1,0,1,0,0,1,0,1; done once; rx_valid=0.
REQ-034 cmd=01, tx_data=8'h3C after cmd=00 -> MOSI = 0,0,0,1,0,0,1,1,1,1,0,0; SS_n high exactly 2 cycles between frames.
REQ-035 cmd=10 tx 8'h5A, then cmd=11, MISO model returns 8'hC3 after RD_LAT=2 -> SS_n low 22 cycles, rx_data=8'hC3 with rx_valid and done in same cycle.
REQ-036 SPI_MASTER_SEQ_CHECK_EN defined, cmd=11 after reset -> err=1 one cycle, SS_n never falls; repeat after cmd=10 -> frame runs.
REQ-037 start pulsed and cmd changed while busy -> frame unchanged, no second frame queued.
